// File: rtl/axis_fifo_burst_ctrl_if.sv
// AXI4-Stream handshake bundle shared by the FIFO read side and the burst consumer side.
interface axis_fifo_burst_ctrl_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_fifo_burst_ctrl.sv
// Burst scheduler: waits for cfg_burst_len buffered words, then passes exactly that many with tlast.
// Optional partial-burst flush on idle timeout is built when AXIS_BURST_CTRL_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | stream blocked; deciding whether enough words are buffered to start a burst
//   BURST | zero-latency pass-through until the latched word count is exhausted
module axis_fifo_burst_ctrl #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNT_WIDTH        = 16,
  parameter int TIMER_WIDTH      = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   cfg_enable,
  input  logic [CNT_WIDTH-1:0]   cfg_burst_len,
  input  logic [TIMER_WIDTH-1:0] cfg_timeout,
  input  logic [CNT_WIDTH-1:0]   fifo_count,
  output logic [31:0]            sts_bursts,
  output logic                   sts_busy,
  axis_fifo_burst_ctrl_if.slave  s_axis,
  axis_fifo_burst_ctrl_if.master m_axis
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 in_burst;
  logic                 beat;
  logic                 start_full;
  logic                 unused_s_tlast;

  assign unused_s_tlast = s_axis.tlast;

  assign in_burst   = (state == BURST);
  assign beat       = in_burst & s_axis.tvalid & m_axis.tready;
  assign start_full = cfg_enable && (cfg_burst_len != '0) && (fifo_count >= cfg_burst_len);

  // Outputs are gated by the registered state so an async reset forces them low at once.
  assign m_axis.tdata  = in_burst ? s_axis.tdata : '0;
  assign m_axis.tvalid = in_burst & s_axis.tvalid;
  assign m_axis.tlast  = in_burst && (remaining == CNT_WIDTH'(1));
  assign s_axis.tready = in_burst & m_axis.tready;
  assign sts_busy      = in_burst;

`ifdef AXIS_BURST_CTRL_TIMEOUT_EN
  logic [TIMER_WIDTH-1:0] timer;
  logic                   tmo_cond;

  assign tmo_cond = cfg_enable && (cfg_timeout != '0) && (fifo_count != '0)
                    && (fifo_count < cfg_burst_len);
`else
  logic [TIMER_WIDTH-1:0] unused_cfg_timeout;

  assign unused_cfg_timeout = cfg_timeout;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      remaining  <= '0;
      sts_bursts <= '0;
`ifdef AXIS_BURST_CTRL_TIMEOUT_EN
      timer      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_full) begin
            remaining <= cfg_burst_len;
            state     <= BURST;
`ifdef AXIS_BURST_CTRL_TIMEOUT_EN
            timer     <= '0;
          end else if (tmo_cond) begin
            // Flush once the idle count would reach cfg_timeout on this edge.
            if (TIMER_WIDTH'(timer + 1'b1) == cfg_timeout) begin
              remaining <= fifo_count;
              state     <= BURST;
              timer     <= '0;
            end else begin
              timer <= TIMER_WIDTH'(timer + 1'b1);
            end
          end else begin
            timer <= '0;
`endif
          end
        end
        BURST: begin
`ifdef AXIS_BURST_CTRL_TIMEOUT_EN
          timer <= '0;
`endif
          if (beat) begin
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state      <= IDLE;
              sts_bursts <= sts_bursts + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fifo_burst_ctrl.sv
// Directed bench: models the FIFO read side and a consumer, checks burst framing, timing and reset.
module tb_axis_fifo_burst_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_burst_len = '0;
  logic [31:0] cfg_timeout = '0;
  logic [15:0] fifo_count;
  logic [31:0] sts_bursts;
  logic        sts_busy;

  axis_fifo_burst_ctrl_if #(.TDATA_WIDTH(32)) s_if ();
  axis_fifo_burst_ctrl_if #(.TDATA_WIDTH(32)) m_if ();

  axis_fifo_burst_ctrl #(
    .AXIS_TDATA_WIDTH(32), .CNT_WIDTH(16), .TIMER_WIDTH(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_enable(cfg_enable),
    .cfg_burst_len(cfg_burst_len), .cfg_timeout(cfg_timeout), .fifo_count(fifo_count),
    .sts_bursts(sts_bursts), .sts_busy(sts_busy), .s_axis(s_if.slave), .m_axis(m_if.master)
  );

  always #5 aclk = ~aclk;

  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        stall = 1'b0;
  logic        ready = 1'b0;
  logic        pop_pending = 1'b0;
  int          cyc = 0;

  assign s_if.tdata  = mem[rd_ptr[7:0]];
  assign s_if.tvalid = (wr_ptr != rd_ptr) && !stall;
  assign s_if.tlast  = 1'b0;
  assign fifo_count  = 16'(wr_ptr - rd_ptr);
  assign m_if.tready = ready;

  logic [31:0] out_data [$];
  logic        out_last [$];
  int          out_cyc  [$];

  always @(negedge aclk) begin
    if (m_if.tvalid && m_if.tready) begin
      out_data.push_back(m_if.tdata);
      out_last.push_back(m_if.tlast);
      out_cyc.push_back(cyc);
    end
    pop_pending <= s_if.tvalid && s_if.tready;
  end

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (pop_pending) rd_ptr <= rd_ptr + 1;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_bursts(input string tag, input logic [31:0] n, input int budget);
    int k = 0;
    while (sts_bursts != n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, sts_bursts, n);
  endtask

  task automatic wait_busy(input string tag, input int budget);
    int k = 0;
    while (!sts_busy && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 32'(sts_busy), 32'd1);
  endtask

  function automatic logic [31:0] last_bits(input int start, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++)
      if (start + i < out_last.size()) r[i] = out_last[start + i];
    return r;
  endfunction

  function automatic logic [31:0] data_at(input int idx);
    if (idx < out_data.size()) return out_data[idx];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int idx);
    if (idx < out_cyc.size()) return out_cyc[idx];
    return -1000;
  endfunction

  initial begin
    int base;
    int t0;
    int k;

    #2 aresetn = 1'b0;
    #1;
    check("rst_bursts", sts_bursts, 32'd0);
    check("rst_busy", 32'(sts_busy), 32'd0);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd0);
    check("rst_m_tdata", m_if.tdata, 32'd0);
    tick(3);
    aresetn = 1'b1;

    // 1: three words below len=4, no timeout -> nothing moves
    cfg_burst_len = 16'd4;
    cfg_enable = 1'b1;
    ready = 1'b1;
    push(32'h100); push(32'h101); push(32'h102);
    tick(20);
    check("t1_no_beats", 32'(out_data.size()), 32'd0);
    check("t1_s_tready", 32'(s_if.tready), 32'd0);
    check("t1_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("t1_busy", 32'(sts_busy), 32'd0);

    // 2: eight buffered -> two back-to-back 4-word bursts
    for (int i = 3; i < 8; i++) push(32'h100 + 32'(i));
    wait_bursts("t2_bursts", 32'd2, 60);
    tick(2);
    check("t2_count", 32'(out_data.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t2_data", data_at(i), 32'h100 + 32'(i));
    check("t2_tlast", last_bits(0, 8), 32'h88);
    check("t2_burst_span", 32'(cyc_at(3) - cyc_at(0)), 32'd3);
    check("t2_idle_gap", 32'(cyc_at(4) - cyc_at(3)), 32'd2);
    check("t2_fifo_empty", 32'(fifo_count), 32'd0);

    // 3: ready toggling then source stall; burst stays open and completes at 4
    base = out_data.size();
    ready = 1'b0;
    push(32'h200); push(32'h201); push(32'h202); push(32'h203);
    wait_busy("t3_busy", 20);
    ready = 1'b1; tick(1);
    ready = 1'b0; tick(1);
    ready = 1'b1; tick(1);
    ready = 1'b0; tick(1);
    stall = 1'b1;
    ready = 1'b1;
    tick(5);
    check("t3_beats_mid", 32'(out_data.size() - base), 32'd2);
    check("t3_busy_stall", 32'(sts_busy), 32'd1);
    stall = 1'b0;
    wait_bursts("t3_bursts", 32'd3, 30);
    tick(2);
    check("t3_count", 32'(out_data.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("t3_data", data_at(base + i), 32'h200 + 32'(i));
    check("t3_tlast", last_bits(base, 4), 32'h8);

    // 4: mid-burst config change only applies at the next decision
    base = out_data.size();
    push(32'h300); push(32'h301); push(32'h302); push(32'h303);
    wait_busy("t4_busy", 20);
    cfg_burst_len = 16'd2;
    cfg_enable = 1'b0;
    push(32'h304); push(32'h305); push(32'h306); push(32'h307);
    wait_bursts("t4_first", 32'd4, 30);
    tick(10);
    check("t4_len_kept", 32'(out_data.size() - base), 32'd4);
    check("t4_no_new", 32'(sts_busy), 32'd0);
    check("t4_tlast_a", last_bits(base, 4), 32'h8);
    cfg_enable = 1'b1;
    wait_bursts("t4_short", 32'd6, 30);
    tick(2);
    check("t4_count", 32'(out_data.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) check("t4_data", data_at(base + i), 32'h300 + 32'(i));
    check("t4_tlast_b", last_bits(base, 8), 32'hA8);

    // 5: partial burst via timeout (only when the feature is built)
    base = out_data.size();
    cfg_burst_len = 16'd16;
    cfg_timeout = 32'd10;
    push(32'h500); push(32'h501); push(32'h502);
    t0 = cyc;
`ifdef AXIS_BURST_CTRL_TIMEOUT_EN
    wait_bursts("t5_bursts", 32'd7, 40);
    tick(2);
    check("t5_start_delay", 32'(cyc_at(base) - t0), 32'd10);
    check("t5_count", 32'(out_data.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) check("t5_data", data_at(base + i), 32'h500 + 32'(i));
    check("t5_tlast", last_bits(base, 3), 32'h4);
`else
    tick(30);
    check("t5_no_beats", 32'(out_data.size() - base), 32'd0);
    check("t5_s_tready", 32'(s_if.tready), 32'd0);
    check("t5_bursts", sts_bursts, 32'd6);
`endif
    cfg_timeout = 32'd0;

    // 6: async reset after two beats, then a fresh burst from the leftovers
    cfg_enable = 1'b0;
    rd_ptr = wr_ptr;
    cfg_burst_len = 16'd4;
    push(32'h600); push(32'h601); push(32'h602); push(32'h603);
    base = out_data.size();
    cfg_enable = 1'b1;
    k = 0;
    while (out_data.size() - base < 2 && k < 30) begin
      tick(1);
      k++;
    end
    check("t6_two_beats", 32'(out_data.size() - base), 32'd2);
    aresetn = 1'b0;
    #1;
    check("t6_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("t6_rst_s_tready", 32'(s_if.tready), 32'd0);
    check("t6_rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("t6_rst_busy", 32'(sts_busy), 32'd0);
    check("t6_rst_bursts", sts_bursts, 32'd0);
    tick(2);
    check("t6_no_tlast", last_bits(base, 2), 32'h0);
    check("t6_fifo_left", 32'(fifo_count), 32'd2);
    aresetn = 1'b1;
    base = out_data.size();
    push(32'h604); push(32'h605);
    wait_bursts("t6_bursts", 32'd1, 30);
    tick(2);
    check("t6_count", 32'(out_data.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) check("t6_data", data_at(base + i), 32'h602 + 32'(i));
    check("t6_tlast", last_bits(base, 4), 32'h8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
